predicted_digit_argmax: RTL and testbench
=========================================

PREDICTED_DIGIT_ARGMAX -- requirements
Module: predicted_digit_argmax

Interface
REQ-001 Parameter NEURON_NUMBER, default 10, count of activations scanned; legal range 2..256.
REQ-002 Parameter RESOLUTION, default 8, bits per activation; legal range 2..32.
REQ-003 Parameter SIGNED_MODE, default 0: 0 compares activations as unsigned, 1 as two's complement.
REQ-004 Parameter MARGIN_THRESHOLD, default 4, unsigned margin below which a result is flagged low-confidence.
REQ-005 Derived localparam IDX_W = max(1, clog2(NEURON_NUMBER)); not overridable.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 digit_en  input  1  start request; sampled on rising edge.
REQ-009 abort  input  1  synchronous cancel of a scan in progress.
REQ-010 output_activations  input  RESOLUTION*NEURON_NUMBER  activation vector; neuron i at bits [i*RESOLUTION +: RESOLUTION].
REQ-011 busy  output  1  high while in SCAN.
REQ-012 done  output  1  one-cycle pulse marking a new result.
REQ-013 predicted_digit  output  IDX_W  index of the maximum activation.
REQ-014 max_value  output  RESOLUTION  winning activation value.
REQ-015 margin  output  RESOLUTION+1  max_value minus runner-up, unsigned.
REQ-016 low_conf  output  1  high when margin < MARGIN_THRESHOLD.

Function
REQ-017 FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-018 digit_en high in IDLE or DONE: capture output_activations into an internal snapshot, load best=element 0, best_idx=0, second=minimum representable value (0 unsigned, -2^(RESOLUTION-1) signed), cnt=1, enter SCAN.
REQ-019 digit_en in SCAN shall be ignored; the input vector shall not be resampled during a scan.
REQ-020 Each SCAN edge processes snapshot element cnt: if element >= best then second=best, best=element, best_idx=cnt; else if element > second then second=element; then cnt=cnt+1.
REQ-021 Ties: the higher index wins, and margin for a tied maximum is 0.
REQ-022 When the processed element is NEURON_NUMBER-1, the same edge enters DONE and registers predicted_digit, max_value, margin, low_conf from the final comparison result.
REQ-023 Latency: digit_en sampled at edge E -> done high from edge E+NEURON_NUMBER-1 to E+NEURON_NUMBER; busy high for exactly NEURON_NUMBER-1 cycles.
REQ-024 DONE lasts one cycle, then returns to IDLE unless digit_en is high, in which case it goes directly to SCAN (back-to-back, no idle cycle).
REQ-025 margin = best - second computed in RESOLUTION+1 bits, sign-extended when SIGNED_MODE=1 and zero-extended otherwise; never negative.
REQ-026 abort high in SCAN: next state IDLE, no done pulse, result outputs unchanged; abort has priority over scan completion on the same edge; abort is ignored outside SCAN.
REQ-027 Result outputs hold their last value until the next DONE entry.
REQ-028 Comparisons shall use SIGNED_MODE semantics for both the best and second updates.

Reset
REQ-029 reset high shall force, asynchronously: state IDLE, busy=0, done=0, predicted_digit=0, max_value=0, margin=0, low_conf=1, cnt=0.
REQ-030 reset asserted mid-scan discards the scan, and no done pulse follows reset release.
REQ-031 The first edge after reset deassertion may accept digit_en.

Verification
REQ-032 N=10, R=8 unsigned, activations {3,9,200,7,...,0}, digit_en at edge 0 -> done at edge 9, predicted_digit=2, max_value=200, margin=191, low_conf=0.
REQ-033 Tie: elements 4 and 7 both 0xF0 and all others 0x10 -> predicted_digit=7, margin=0, low_conf=1.
REQ-034 SIGNED_MODE=1: activations all -5 except element 3 = -2 -> predicted_digit=3, max_value=0xFE, margin=3, low_conf=1; the same vector with SIGNED_MODE=0 -> predicted_digit=3 (0xFE is the largest unsigned value).
REQ-035 Back-to-back: digit_en held high continuously -> done pulses every 10 cycles, with busy low for one cycle between scans; output_activations changed during a scan does not affect that scan's result.
REQ-036 abort at SCAN cycle 4 -> IDLE next cycle, no done, previous results retained; a separate test asserts reset at SCAN cycle 5 -> all outputs return to their reset values immediately, with no done pulse afterwards.

Source files
------------

// File: rtl/predicted_digit_argmax_if.sv
// rtl/predicted_digit_argmax_if.sv - start/abort/activation inputs and result outputs of the argmax scanner
interface predicted_digit_argmax_if #(
    parameter int NEURON_NUMBER = 10,
    parameter int RESOLUTION    = 8
) ();
    localparam int IDX_W = (NEURON_NUMBER > 2) ? $clog2(NEURON_NUMBER) : 1;

    logic                                digit_en;
    logic                                abort;
    logic [RESOLUTION*NEURON_NUMBER-1:0] output_activations;
    logic                                busy;
    logic                                done;
    logic [IDX_W-1:0]                    predicted_digit;
    logic [RESOLUTION-1:0]               max_value;
    logic [RESOLUTION:0]                 margin;
    logic                                low_conf;

    modport master (
        output digit_en, abort, output_activations,
        input  busy, done, predicted_digit, max_value, margin, low_conf
    );

    modport slave (
        input  digit_en, abort, output_activations,
        output busy, done, predicted_digit, max_value, margin, low_conf
    );
endinterface

// File: rtl/predicted_digit_argmax.sv
// rtl/predicted_digit_argmax.sv - sequential argmax over a snapshotted activation vector with runner-up margin
module predicted_digit_argmax #(
    parameter int          NEURON_NUMBER    = 10,
    parameter int          RESOLUTION       = 8,
    parameter int          SIGNED_MODE      = 0,
    parameter int unsigned MARGIN_THRESHOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    predicted_digit_argmax_if.slave bus
);
    localparam int IDX_W = (NEURON_NUMBER > 2) ? $clog2(NEURON_NUMBER) : 1;
    localparam int VEC_W = RESOLUTION * NEURON_NUMBER;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_NUMBER - 1);
    localparam logic [RESOLUTION-1:0] MIN_VAL =
        (SIGNED_MODE != 0) ? {1'b1, {(RESOLUTION-1){1'b0}}} : '0;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_next;

    logic [VEC_W-1:0]      snapshot;
    logic [RESOLUTION-1:0] best, second, elem, best_next, second_next;
    logic [IDX_W-1:0]      best_idx, best_idx_next, cnt;
    logic [RESOLUTION:0]   margin_next;
    logic                  low_conf_next;
    logic                  load, step, finish;

    logic [IDX_W-1:0]      res_digit;
    logic [RESOLUTION-1:0] res_max;
    logic [RESOLUTION:0]   res_margin;
    logic                  res_low_conf;

    // Flipping the MSB maps two's complement order onto unsigned order; MIN_VAL is zero when unsigned.
    function automatic logic [RESOLUTION-1:0] order_key(input logic [RESOLUTION-1:0] v);
        return v ^ MIN_VAL;
    endfunction

    function automatic logic [RESOLUTION:0] widen(input logic [RESOLUTION-1:0] v);
        return {(SIGNED_MODE != 0) && v[RESOLUTION-1], v};
    endfunction

    assign elem = snapshot[32'(cnt) * RESOLUTION +: RESOLUTION];

    always_comb begin
        best_next     = best;
        second_next   = second;
        best_idx_next = best_idx;
        if (order_key(elem) >= order_key(best)) begin
            second_next   = best;
            best_next     = elem;
            best_idx_next = cnt;
        end else if (order_key(elem) > order_key(second)) begin
            second_next = elem;
        end
        margin_next   = widen(best_next) - widen(second_next);
        low_conf_next = 64'(margin_next) < 64'(MARGIN_THRESHOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.digit_en ? SCAN : IDLE;
            SCAN:    if (bus.abort)            state_next = IDLE;
                     else if (cnt == LAST_IDX) state_next = DONE;
            DONE:    state_next = bus.digit_en ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SCAN);
        bus.done = (state == DONE);
        load     = bus.digit_en && (state != SCAN);
        step     = (state == SCAN) && !bus.abort;
        finish   = step && (cnt == LAST_IDX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot     <= '0;
            best         <= '0;
            second       <= '0;
            best_idx     <= '0;
            cnt          <= '0;
            res_digit    <= '0;
            res_max      <= '0;
            res_margin   <= '0;
            res_low_conf <= 1'b1;
        end else if (load) begin
            snapshot <= bus.output_activations;
            best     <= bus.output_activations[RESOLUTION-1:0];
            best_idx <= '0;
            second   <= MIN_VAL;
            cnt      <= IDX_W'(1);
        end else if (step) begin
            best     <= best_next;
            second   <= second_next;
            best_idx <= best_idx_next;
            cnt      <= cnt + IDX_W'(1);
            if (finish) begin
                res_digit    <= best_idx_next;
                res_max      <= best_next;
                res_margin   <= margin_next;
                res_low_conf <= low_conf_next;
            end
        end
    end

    assign bus.predicted_digit = res_digit;
    assign bus.max_value       = res_max;
    assign bus.margin          = res_margin;
    assign bus.low_conf        = res_low_conf;
endmodule

// File: tb/tb_predicted_digit_argmax.sv
// tb/tb_predicted_digit_argmax.sv - directed-vector bench for predicted_digit_argmax
module tb_predicted_digit_argmax;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    predicted_digit_argmax_if #(.NEURON_NUMBER(10), .RESOLUTION(8)) bus_u ();
    predicted_digit_argmax_if #(.NEURON_NUMBER(10), .RESOLUTION(8)) bus_s ();

    predicted_digit_argmax #(.NEURON_NUMBER(10), .RESOLUTION(8), .SIGNED_MODE(0), .MARGIN_THRESHOLD(4))
        u_dut (.clk(clk), .reset(reset), .bus(bus_u));
    predicted_digit_argmax #(.NEURON_NUMBER(10), .RESOLUTION(8), .SIGNED_MODE(1), .MARGIN_THRESHOLD(4))
        u_dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    function automatic logic [79:0] fill(input logic [7:0] val);
        logic [79:0] r;
        for (int i = 0; i < 10; i++) r[i*8 +: 8] = val;
        return r;
    endfunction

    function automatic logic [79:0] basic_vec();
        logic [79:0] r;
        r = fill(8'd0);
        r[7:0] = 8'd3; r[15:8] = 8'd9; r[23:16] = 8'd200; r[31:24] = 8'd7;
        return r;
    endfunction

    // Starts a scan on both instances and returns edges from the sampling edge until done is seen.
    task automatic run_scan(input logic [79:0] v, output int lat);
        @(negedge clk);
        bus_u.output_activations = v; bus_s.output_activations = v;
        bus_u.digit_en = 1'b1;        bus_s.digit_en = 1'b1;
        @(posedge clk); #1;
        bus_u.digit_en = 1'b0;        bus_s.digit_en = 1'b0;
        lat = 0;
        while (!bus_u.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        checks++; if (bus_u.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus_u.busy); end
        checks++; if (bus_u.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", bus_u.done); end
        checks++; if (bus_u.predicted_digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", bus_u.predicted_digit); end
        checks++; if (bus_u.max_value !== 8'd0) begin errors++; $display("FAIL reset_max: got %0d expected 0", bus_u.max_value); end
        checks++; if (bus_u.margin !== 9'd0) begin errors++; $display("FAIL reset_margin: got %0d expected 0", bus_u.margin); end
        checks++; if (bus_u.low_conf !== 1'b1) begin errors++; $display("FAIL reset_low_conf: got %0b expected 1", bus_u.low_conf); end
        checks++; if (bus_s.low_conf !== 1'b1) begin errors++; $display("FAIL reset_low_conf_s: got %0b expected 1", bus_s.low_conf); end
    endtask

    task automatic test_first_edge();
        int lat;
        @(negedge clk);
        reset = 1'b0;
        bus_u.output_activations = basic_vec();
        bus_u.digit_en = 1'b1;
        @(posedge clk); #1;
        bus_u.digit_en = 1'b0;
        checks++; if (bus_u.busy !== 1'b1) begin errors++; $display("FAIL first_edge_busy: got %0b expected 1", bus_u.busy); end
        lat = 0;
        while (!bus_u.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        checks++; if (bus_u.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b expected 0", bus_u.busy); end
        checks++; if (bus_u.predicted_digit !== 4'd2) begin errors++; $display("FAIL basic_digit: got %0d expected 2", bus_u.predicted_digit); end
        checks++; if (bus_u.max_value !== 8'd200) begin errors++; $display("FAIL basic_max: got %0d expected 200", bus_u.max_value); end
        checks++; if (bus_u.margin !== 9'd191) begin errors++; $display("FAIL basic_margin: got %0d expected 191", bus_u.margin); end
        checks++; if (bus_u.low_conf !== 1'b0) begin errors++; $display("FAIL basic_low_conf: got %0b expected 0", bus_u.low_conf); end
        @(posedge clk); #1;
        checks++; if (bus_u.done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %0b expected 0", bus_u.done); end
        checks++; if (bus_u.predicted_digit !== 4'd2) begin errors++; $display("FAIL basic_hold: got %0d expected 2", bus_u.predicted_digit); end
    endtask

    task automatic test_tie();
        int lat;
        logic [79:0] v;
        v = fill(8'h10);
        v[4*8 +: 8] = 8'hF0; v[7*8 +: 8] = 8'hF0;
        run_scan(v, lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL tie_latency: got %0d expected 9", lat); end
        checks++; if (bus_u.predicted_digit !== 4'd7) begin errors++; $display("FAIL tie_digit: got %0d expected 7", bus_u.predicted_digit); end
        checks++; if (bus_u.max_value !== 8'hF0) begin errors++; $display("FAIL tie_max: got %0h expected f0", bus_u.max_value); end
        checks++; if (bus_u.margin !== 9'd0) begin errors++; $display("FAIL tie_margin: got %0d expected 0", bus_u.margin); end
        checks++; if (bus_u.low_conf !== 1'b1) begin errors++; $display("FAIL tie_low_conf: got %0b expected 1", bus_u.low_conf); end
    endtask

    task automatic test_margin_boundary();
        int lat;
        logic [79:0] v;
        v = fill(8'h10);
        v[9*8 +: 8] = 8'h14;
        run_scan(v, lat);
        checks++; if (bus_u.predicted_digit !== 4'd9) begin errors++; $display("FAIL edge_digit: got %0d expected 9", bus_u.predicted_digit); end
        checks++; if (bus_u.margin !== 9'd4) begin errors++; $display("FAIL edge_margin: got %0d expected 4", bus_u.margin); end
        checks++; if (bus_u.low_conf !== 1'b0) begin errors++; $display("FAIL edge_low_conf: got %0b expected 0", bus_u.low_conf); end
    endtask

    task automatic test_signed();
        int lat;
        logic [79:0] v;
        v = fill(8'hFB);
        v[3*8 +: 8] = 8'hFE;
        run_scan(v, lat);
        checks++; if (!bus_s.done) begin errors++; $display("FAIL signed_done: got %0b expected 1", bus_s.done); end
        checks++; if (bus_s.predicted_digit !== 4'd3) begin errors++; $display("FAIL signed_digit: got %0d expected 3", bus_s.predicted_digit); end
        checks++; if (bus_s.max_value !== 8'hFE) begin errors++; $display("FAIL signed_max: got %0h expected fe", bus_s.max_value); end
        checks++; if (bus_s.margin !== 9'd3) begin errors++; $display("FAIL signed_margin: got %0d expected 3", bus_s.margin); end
        checks++; if (bus_s.low_conf !== 1'b1) begin errors++; $display("FAIL signed_low_conf: got %0b expected 1", bus_s.low_conf); end
        checks++; if (bus_u.predicted_digit !== 4'd3) begin errors++; $display("FAIL unsigned_fe_digit: got %0d expected 3", bus_u.predicted_digit); end

        v = fill(8'h00);
        v[7:0] = 8'h7F; v[5*8 +: 8] = 8'h80;
        run_scan(v, lat);
        checks++; if (bus_s.predicted_digit !== 4'd0) begin errors++; $display("FAIL signed_order_digit: got %0d expected 0", bus_s.predicted_digit); end
        checks++; if (bus_s.margin !== 9'd127) begin errors++; $display("FAIL signed_order_margin: got %0d expected 127", bus_s.margin); end
        checks++; if (bus_u.predicted_digit !== 4'd5) begin errors++; $display("FAIL unsigned_order_digit: got %0d expected 5", bus_u.predicted_digit); end
        checks++; if (bus_u.margin !== 9'd1) begin errors++; $display("FAIL unsigned_order_margin: got %0d expected 1", bus_u.margin); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [79:0] v_tie, v_other;
        v_tie = fill(8'h10);
        v_tie[4*8 +: 8] = 8'hF0; v_tie[7*8 +: 8] = 8'hF0;
        v_other = fill(8'h11);
        v_other[7:0] = 8'h12;
        @(negedge clk);
        bus_u.output_activations = basic_vec();
        bus_u.digit_en = 1'b1;
        @(posedge clk); #1;
        bus_u.output_activations = v_tie;
        lat = 0;
        while (!bus_u.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 9", lat); end
        checks++; if (bus_u.predicted_digit !== 4'd2) begin errors++; $display("FAIL b2b_first_digit: got %0d expected 2", bus_u.predicted_digit); end
        checks++; if (bus_u.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %0b expected 0", bus_u.busy); end
        @(posedge clk); #1;
        checks++; if (bus_u.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %0b expected 1", bus_u.busy); end
        bus_u.output_activations = v_other;
        bus_u.digit_en = 1'b0;
        lat = 1;
        while (!bus_u.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 10) begin errors++; $display("FAIL b2b_period: got %0d expected 10", lat); end
        checks++; if (bus_u.predicted_digit !== 4'd7) begin errors++; $display("FAIL b2b_second_digit: got %0d expected 7", bus_u.predicted_digit); end
        checks++; if (bus_u.margin !== 9'd0) begin errors++; $display("FAIL b2b_second_margin: got %0d expected 0", bus_u.margin); end
    endtask

    task automatic test_abort();
        int lat;
        bit seen;
        logic [79:0] v;
        run_scan(basic_vec(), lat);
        v = fill(8'h11);
        v[7:0] = 8'h12;
        @(negedge clk);
        bus_u.output_activations = v;
        bus_u.digit_en = 1'b1;
        @(posedge clk); #1;
        bus_u.digit_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus_u.abort = 1'b1;
        @(posedge clk); #1;
        bus_u.abort = 1'b0;
        checks++; if (bus_u.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", bus_u.busy); end
        seen = 1'b0;
        repeat (12) begin
            seen = seen | bus_u.done;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %0b expected 0", seen); end
        checks++; if (bus_u.predicted_digit !== 4'd2) begin errors++; $display("FAIL abort_keep_digit: got %0d expected 2", bus_u.predicted_digit); end
        checks++; if (bus_u.max_value !== 8'd200) begin errors++; $display("FAIL abort_keep_max: got %0d expected 200", bus_u.max_value); end
        checks++; if (bus_u.margin !== 9'd191) begin errors++; $display("FAIL abort_keep_margin: got %0d expected 191", bus_u.margin); end
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        @(negedge clk);
        bus_u.output_activations = fill(8'h33);
        bus_u.digit_en = 1'b1;
        @(posedge clk); #1;
        bus_u.digit_en = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (bus_u.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b expected 0", bus_u.busy); end
        checks++; if (bus_u.predicted_digit !== 4'd0) begin errors++; $display("FAIL rst_mid_digit: got %0d expected 0", bus_u.predicted_digit); end
        checks++; if (bus_u.max_value !== 8'd0) begin errors++; $display("FAIL rst_mid_max: got %0d expected 0", bus_u.max_value); end
        checks++; if (bus_u.margin !== 9'd0) begin errors++; $display("FAIL rst_mid_margin: got %0d expected 0", bus_u.margin); end
        checks++; if (bus_u.low_conf !== 1'b1) begin errors++; $display("FAIL rst_mid_low_conf: got %0b expected 1", bus_u.low_conf); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            seen = seen | bus_u.done | bus_u.busy;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %0b expected 0", seen); end
    endtask

    initial begin
        reset = 1'b1;
        bus_u.digit_en = 1'b0; bus_u.abort = 1'b0; bus_u.output_activations = '0;
        bus_s.digit_en = 1'b0; bus_s.abort = 1'b0; bus_s.output_activations = '0;
        test_reset();
        test_first_edge();
        test_tie();
        test_margin_boundary();
        test_signed();
        test_back_to_back();
        test_abort();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
